// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: lane-mode and FSM state encodings plus the mode
// priority decode used by both the drive and sample registers.
package qspi_pkg;

    localparam int QSPI_MAX_BYTES = 4;

    typedef enum logic [1:0] {
        MODE_1 = 2'd0,
        MODE_2 = 2'd1,
        MODE_4 = 2'd2
    } qspi_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } qspi_state_t;

    // Narrowest requested lane set wins when several selects are raised.
    function automatic qspi_mode_t qspi_mode_decode(input logic use1,
                                                    input logic use2,
                                                    input logic use4);
        qspi_mode_t mode;
        if (use1)      mode = MODE_1;
        else if (use2) mode = MODE_2;
        else if (use4) mode = MODE_4;
        else           mode = MODE_1;
        return mode;
    endfunction

    function automatic logic [2:0] qspi_lane_width(input qspi_mode_t mode);
        logic [2:0] width;
        case (mode)
            MODE_2:  width = 3'd2;
            MODE_4:  width = 3'd4;
            default: width = 3'd1;
        endcase
        return width;
    endfunction

endpackage

// File: rtl/qspi_data_drive_reg.sv
// QSPI transmit shift register: latches a left-justified word at load and
// pushes it out 1, 2 or 4 bits per SCLK falling edge on the io pins.
module qspi_data_drive_reg
    import qspi_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        num_bytes,
    input  logic              use_1_io_lines_in,
    input  logic              use_2_io_lines_in,
    input  logic              use_4_io_lines_in,
    input  logic              drive_en,
    output logic              qspi_io0_o,
    output logic              qspi_io1_o,
    output logic              qspi_io2_o,
    output logic              qspi_io3_o,
    output logic [3:0]        qspi_io_oe,
    output logic              busy,
    output logic              done,
    output logic              load_err
);

    localparam logic [2:0] MAX_BYTES = 3'(DATA_W / 8);
    localparam logic [5:0] DATA_W6   = 6'(DATA_W);

    qspi_state_t       r_state;
    qspi_mode_t        r_mode;
    logic [DATA_W-1:0] r_shift;
    logic [5:0]        r_bits_left;
    logic              r_done;
    logic              r_load_err;

    logic              w_mode_valid;
    logic              w_bytes_ok;
    qspi_mode_t        w_mode;
    logic [2:0]        w_width;
    logic [5:0]        w_shamt;
    logic [DATA_W-1:0] w_justified;

    assign w_mode_valid = use_1_io_lines_in | use_2_io_lines_in | use_4_io_lines_in;
    assign w_bytes_ok   = (num_bytes != 3'd0) && (num_bytes <= MAX_BYTES);
    assign w_mode       = qspi_mode_decode(use_1_io_lines_in, use_2_io_lines_in,
                                           use_4_io_lines_in);
    assign w_width      = qspi_lane_width(r_mode);

    // Place byte num_bytes-1 at the MSB so shifting left emits it first.
    assign w_shamt      = DATA_W6 - {num_bytes, 3'b000};
    assign w_justified  = data_in << w_shamt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE_1;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_done      <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        if (w_mode_valid && w_bytes_ok) begin
                            r_mode      <= w_mode;
                            r_shift     <= w_justified;
                            r_bits_left <= {num_bytes, 3'b000};
                            r_state     <= SHIFT;
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (drive_en) begin
                        if (r_bits_left > {3'b000, w_width}) begin
                            r_shift     <= r_shift << w_width;
                            r_bits_left <= r_bits_left - {3'b000, w_width};
                        end else begin
                            r_shift     <= '0;
                            r_bits_left <= '0;
                            r_done      <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pins and enables are decoded purely from registered state.
    always_comb begin
        qspi_io0_o = 1'b0;
        qspi_io1_o = 1'b0;
        qspi_io2_o = 1'b0;
        qspi_io3_o = 1'b0;
        qspi_io_oe = 4'b0000;
        if (r_state == SHIFT) begin
            case (r_mode)
                MODE_2: begin
                    qspi_io1_o = r_shift[DATA_W-1];
                    qspi_io0_o = r_shift[DATA_W-2];
                    qspi_io_oe = 4'b0011;
                end
                MODE_4: begin
                    qspi_io3_o = r_shift[DATA_W-1];
                    qspi_io2_o = r_shift[DATA_W-2];
                    qspi_io1_o = r_shift[DATA_W-3];
                    qspi_io0_o = r_shift[DATA_W-4];
                    qspi_io_oe = 4'b1111;
                end
                default: begin
                    qspi_io0_o = r_shift[DATA_W-1];
                    qspi_io_oe = 4'b0001;
                end
            endcase
        end
    end

    assign busy     = (r_state == SHIFT);
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: doc/qspi_data_drive_reg.md
QSPI_DATA_DRIVE_REG -- requirements
Module: qspi_data_drive_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the shift register width in bits; legal values are multiples of 8 up to 32.
REQ-002 SHALL have ports: clk in 1 system clock (HCLK); rst in 1 reset, synchronous, active-high.
REQ-003 SHALL have ports: load in 1 start-transfer strobe; data_in in DATA_W write data from the AHB/FIFO side; num_bytes in 3 bytes to send, 1..DATA_W/8.
REQ-004 SHALL have ports: use_1_io_lines_in, use_2_io_lines_in, use_4_io_lines_in in 1 each, lane mode select.
REQ-005 SHALL have port drive_en in 1, the drive pulse from the SCLK generator, asserted once per SCLK falling edge.
REQ-006 SHALL have ports: qspi_io0_o..qspi_io3_o out 1 each, pin drive values; qspi_io_oe out 4, per-pin output enable, bit n for ioN.
REQ-007 SHALL have ports: busy out 1, transfer active; done out 1, one-cycle completion pulse; load_err out 1, one-cycle illegal-load pulse.

Function
REQ-008 SHALL implement FSM states IDLE and SHIFT, encoded as the enum from the shared package.
REQ-009 IDLE with load=1 and legal mode/num_bytes: SHALL latch data_in left-justified, so that byte num_bytes-1 occupies the MSB, latch the lane width W (1/2/4), load bits_left=num_bytes*8, and go to SHIFT next cycle.
REQ-010 Mode priority SHALL be 1-line > 2-line > 4-line when several mode inputs are set; the mode SHALL be latched at load and held for the whole transfer.
REQ-011 Load in IDLE with no mode set, num_bytes=0, or num_bytes>DATA_W/8: SHALL stay in IDLE and pulse load_err for 1 cycle.
REQ-012 In SHIFT, outputs SHALL present the top W bits of the shift register: 1-line: io0=bit[MSB]; 2-line: io1=bit[MSB], io0=bit[MSB-1]; 4-line: io3..io0=bits[MSB:MSB-3].
REQ-013 qspi_io_oe SHALL be 4'b0001 (1-line), 4'b0011 (2-line), or 4'b1111 (4-line) while in SHIFT, and 4'b0000 in IDLE.
REQ-014 First bit group SHALL be valid on the pins the cycle after load, with no drive_en required.
REQ-015 drive_en in SHIFT with bits_left>W: SHALL shift left by W with zero fill and decrement bits_left by W; new bits appear on the pins the next cycle.
REQ-016 drive_en in SHIFT with bits_left==W: SHALL go to IDLE, pulse done for exactly 1 cycle, and deassert oe, all in the next cycle.
REQ-017 busy SHALL equal 1 exactly while the state is SHIFT.
REQ-018 load while in SHIFT SHALL be ignored, with no load_err and no state change.
REQ-019 drive_en while in IDLE SHALL be ignored.
REQ-020 Simultaneous load and drive_en in IDLE: load SHALL take effect and drive_en SHALL be ignored.
REQ-021 Number of drive_en pulses per transfer SHALL be exactly num_bytes*8/W; bits_left SHALL never underflow.
REQ-022 Pin outputs in IDLE SHALL be 0.

Reset
REQ-023 rst=1 SHALL force within the same clock edge: state IDLE, shift register 0, bits_left 0, all io outputs 0, qspi_io_oe 0, busy/done/load_err 0.
REQ-024 rst asserted mid-transfer SHALL abort the transfer with no done pulse; load/drive_en SHALL be ignored while rst=1.

Structure
REQ-025 Package qspi_pkg SHALL hold the lane-mode enum (MODE_1, MODE_2, MODE_4), the FSM state enum, and the constant QSPI_MAX_BYTES=4.
REQ-026 SHALL be a single module with no sub-modules; the mode priority decode SHALL be a package function qspi_mode_decode shared with the sample register.

Verification
REQ-027 1-line, data_in=0xA5, num_bytes=1, 8 drive_en pulses -> io0 sequence 1,0,1,0,0,1,0,1; oe=0001; done after the 8th pulse.
REQ-028 4-line, data_in=0x12345678, num_bytes=4 -> io3..io0 nibbles 1,2,3,4,5,6,7,8 across 8 pulses; oe=1111; busy for the whole transfer.
REQ-029 2-line, data_in=0x00C3, num_bytes=2 -> 8 pulses; pairs io1/io0 = 11,00,00,11 for 0xC3 are preceded by 00 x4 for byte 0x00; done once only.
REQ-030 Loopback: drive output connected to qspi_data_sample_reg with the same mode and pulses -> sampled data_out equals data_in for every mode with num_bytes=4.
REQ-031 Errors: load with no mode -> load_err pulse, busy stays 0; load with num_bytes=5 -> load_err; load during SHIFT -> ignored, transfer completes unchanged.
REQ-032 Reset after 3 pulses of a quad transfer -> next cycle all outputs 0, no done; a new load then completes normally.
